muldiv_seq: RTL and testbench

- Iterative multi-cycle sequencer for the RV32M operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the combinational ALU in the execute stage. Decode steers M-extension alucodes here instead of to the ALU.
- Execute stalls while busy is high and writes result back when the done pulse fires.
- Uses one shared 32-bit adder/subtractor, sequenced by a single FSM over 32 radix-2 iterations.

---
 rtl/muldiv_seq_pkg.sv | 24 ++
 rtl/muldiv_seq_step.sv | 30 +++
 rtl/muldiv_seq.sv | 152 +++++++++++++++
 tb/tb_muldiv_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer.
package muldiv_seq_pkg;

  // Last alucode of the base ALU set; M codes are numbered after it.
  localparam logic [5:0] ALU_ADD       = 6'd0;
  localparam logic [5:0] ALU_BASE_LAST = 6'd17;

  localparam logic [5:0] ALU_MUL    = ALU_BASE_LAST + 6'd1;
  localparam logic [5:0] ALU_MULH   = ALU_BASE_LAST + 6'd2;
  localparam logic [5:0] ALU_MULHSU = ALU_BASE_LAST + 6'd3;
  localparam logic [5:0] ALU_MULHU  = ALU_BASE_LAST + 6'd4;
  localparam logic [5:0] ALU_DIV    = ALU_BASE_LAST + 6'd5;
  localparam logic [5:0] ALU_DIVU   = ALU_BASE_LAST + 6'd6;
  localparam logic [5:0] ALU_REM    = ALU_BASE_LAST + 6'd7;
  localparam logic [5:0] ALU_REMU   = ALU_BASE_LAST + 6'd8;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;

  // True for any alucode that belongs to this unit.
  function automatic logic is_muldiv(input logic [5:0] code);
    return (code >= ALU_MUL) && (code <= ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One radix-2 iteration over a shared adder/subtractor.
// Multiply: acc = {partial_hi, multiplier}; add operand when lsb set, shift right.
// Divide:   acc = {remainder, dividend/quotient}; shift left, trial-subtract operand.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic              is_div_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] add_a, add_b, sum;
  logic          sub;

  // Shared 33-bit add/sub; divide uses the carry-out bit as the borrow flag.
  always_comb begin
    sub   = is_div_i;
    add_a = is_div_i ? acc_i[2*XLEN-1:XLEN-1] : {1'b0, acc_i[2*XLEN-1:XLEN]};
    add_b = (is_div_i || acc_i[0]) ? {1'b0, opnd_i} : '0;
    sum   = add_a + (add_b ^ {(XLEN+1){sub}}) + {{XLEN{1'b0}}, sub};
    if (!is_div_i)
      acc_o = {sum, acc_i[XLEN-1:1]};
    else if (!sum[XLEN])
      acc_o = {sum[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    else
      acc_o = {acc_i[2*XLEN-2:0], 1'b0};
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M sequencer: PREP (signs, specials) -> 32x CALC -> FIX (sign, select) -> DONE.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      alucode,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITER);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [5:0]        code_q, code_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d, result_q, result_d;
  logic              done_q, done_d;

  logic              is_div, is_rem, sgn1, sgn2, s1, s2, div0, ovf;
  logic [XLEN-1:0]   mag1, mag2, quo, rem;
  logic [2*XLEN-1:0] prod;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (b_q),
    .is_div_i (is_div),
    .acc_o    (acc_step)
  );

  // Operation decode and sign/magnitude prep from the captured operands.
  always_comb begin
    is_div = code_q >= ALU_DIV;
    is_rem = (code_q == ALU_REM) || (code_q == ALU_REMU);
    sgn1   = (code_q == ALU_MULH) || (code_q == ALU_MULHSU) ||
             (code_q == ALU_DIV)  || (code_q == ALU_REM);
    sgn2   = (code_q == ALU_MULH) || (code_q == ALU_DIV) || (code_q == ALU_REM);
    s1     = sgn1 && a_q[XLEN-1];
    s2     = sgn2 && b_q[XLEN-1];
    mag1   = s1 ? -a_q : a_q;
    mag2   = s2 ? -b_q : b_q;
    div0   = is_div && (b_q == '0);
    ovf    = (code_q == ALU_DIV || code_q == ALU_REM) &&
             (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    prod   = neg_q ? -acc_q : acc_q;
    quo    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem    = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  // Next-state logic; flush overrides everything outside IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    res_d    = res_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start && is_muldiv(alucode) && !flush) begin
        state_d = PREP;
        code_d  = alucode;
        a_d     = op1;
        b_d     = op2;
      end
      PREP: begin
        cnt_d = '0;
        if (div0) begin
          res_d   = is_rem ? a_q : '1;
          state_d = DONE;
        end else if (ovf) begin
          res_d   = is_rem ? '0 : a_q;
          state_d = DONE;
        end else begin
          acc_d   = {{XLEN{1'b0}}, mag1};
          b_d     = mag2;
          neg_d   = is_rem ? s1 : (s1 ^ s2);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER-1)) state_d = FIX;
      end
      FIX: begin
        if (code_q == ALU_MUL)     res_d = prod[XLEN-1:0];
        else if (!is_div)          res_d = prod[2*XLEN-1:XLEN];
        else if (is_rem)           res_d = rem;
        else                       res_d = quo;
        state_d = DONE;
      end
      DONE: begin
        result_d = res_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, random vs. arithmetic model, corner sequences.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  alucode = '0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alucode(alucode),
    .op1(op1), .op2(op2), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Arithmetic reference built straight from RV32M semantics.
  function automatic logic [31:0] ref_res(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
    ia = int'(a); ib = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (c)
      ALU_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
      ALU_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      ALU_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      ALU_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      ALU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default:    return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    if (c >= ALU_DIV && b == 0) return 2;
    if ((c == ALU_DIV || c == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  // Issue one op from IDLE and measure done latency, pulse count and result.
  task automatic do_op(input string nm, input logic [5:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int first, pulses;
    logic [31:0] got;
    first = 0; pulses = 0; got = '0;
    alucode = c; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first == 0) begin first = n; got = result; end
      end
    end
    chk({nm, " latency"}, 32'(first), 32'(lat));
    chk({nm, " result"}, got, exp);
    chk({nm, " pulses"}, 32'(pulses), 32'd1);
  endtask

  vec_t vecs[12];

  initial begin
    int pulses, first;
    logic [31:0] prev, a, b;
    logic [5:0] c;

    vecs[0]  = '{ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35};
    vecs[1]  = '{ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35};
    vecs[2]  = '{ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35};
    vecs[3]  = '{ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35};
    vecs[4]  = '{ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35};
    vecs[5]  = '{ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35};
    vecs[6]  = '{ALU_DIVU,   32'd100,       32'd7,         32'd14,        35};
    vecs[7]  = '{ALU_REMU,   32'd100,       32'd7,         32'd2,         35};
    vecs[8]  = '{ALU_DIVU,   32'h1357_9BDF, 32'd0,         32'hFFFF_FFFF, 2};
    vecs[9]  = '{ALU_REM,    32'h0000_1234, 32'd0,         32'h0000_1234, 2};
    vecs[10] = '{ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[11] = '{ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2};

    // Reset state
    #12;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Random operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      c = ALU_MUL + 6'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op($sformatf("rand%0d", i), c, a, b, ref_res(c, a, b), ref_lat(c, a, b));
    end

    // Flush in CALC cycle 10: no done, result keeps previous value
    do_op("pre-flush", ALU_MUL, 32'd3, 32'd5, 32'd15, 35);
    prev = result;
    alucode = ALU_DIVU; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'd0);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("flush no done", 32'(pulses), 32'd0);
    chk("flush result", result, prev);

    // start and flush together in IDLE
    alucode = ALU_MUL; op1 = 32'd2; op2 = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start+flush busy", {31'b0, busy}, 32'd0);

    // Non-M alucode is ignored
    alucode = ALU_ADD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("alu_add busy", {31'b0, busy}, 32'd0);

    // start held while busy with a different op: second op waits for IDLE
    alucode = ALU_MUL; op1 = 32'd6; op2 = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    alucode = ALU_DIVU; op1 = 32'd100; op2 = 32'd7;
    first = 0;
    for (int n = 1; n <= 40 && first == 0; n++) begin
      @(posedge clk); #1;
      if (done) begin first = n; chk("held first result", result, 32'd54); end
    end
    chk("held first latency", 32'(first), 32'd35);
    @(posedge clk); #1;
    start = 1'b0;
    first = 0;
    for (int n = 1; n <= 40 && first == 0; n++) begin
      @(posedge clk); #1;
      if (done) first = n;
    end
    chk("held second latency", 32'(first), 32'd35);
    chk("held second result", result, 32'd14);

    // Reset mid-operation, then a fresh start is accepted
    alucode = ALU_MUL; op1 = 32'd11; op2 = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset done", {31'b0, done}, 32'd0);
    chk("midreset result", result, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post-reset", ALU_MUL, 32'd11, 32'd13, 32'd143, 35);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
